// File: rtl/bidir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bidir_pkg
// Description : Shared types and constants for the bidir_xcvr transceiver.
// Revision    : 1.0 - initial release
// ============================================================================
package bidir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A2B  = 2'd1,
        B2A  = 2'd2,
        TURN = 2'd3
    } xcvr_state_t;

    localparam logic DIR_A2B = 1'b1;
    localparam logic DIR_B2A = 1'b0;

    // Map a requested direction onto the matching driving state
    function automatic xcvr_state_t dir_state(input logic dir);
        return (dir == DIR_B2A) ? B2A : A2B;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bidir_turn_timer.sv
`default_nettype none
// ============================================================================
// Module      : bidir_turn_timer
// Description : 8-bit down-counter timing the high-Z turnaround gap.
//               load presets TURN_CYCLES-1; done is high while the count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bidir_turn_timer #(
    parameter int TURN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [7:0] LOAD_VAL = 8'(TURN_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: preset on load, otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/bidir_xcvr.sv
`default_nettype none
// ============================================================================
// Module      : bidir_xcvr
// Description : Clocked bidirectional transceiver between inout buses a and b.
//               A direction FSM inserts TURN_CYCLES of high-Z on every
//               direction change so both sides are never driven together.
//               Macro BIDIR_XCVR_REG_EN: when defined, the data paths are
//               registered (one clock latency); otherwise pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module bidir_xcvr
    import bidir_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             en,
    input  logic             dir_req,
    output logic             drive_b,
    output logic             drive_a,
    output logic             turning,
    output logic [CNT_W-1:0] switch_cnt
);

    xcvr_state_t      state_q;
    xcvr_state_t      state_d;
    logic             prev_dir_q;
    logic             prev_dir_d;
    logic [CNT_W-1:0] switch_cnt_q;
    logic [CNT_W-1:0] switch_cnt_d;
    logic             turn_load;
    logic             turn_done;
    logic             cur_dir;
    logic [WIDTH-1:0] data_ab;
    logic [WIDTH-1:0] data_ba;

    bidir_turn_timer #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_turn_timer (
        .clk (clk),
        .rst (rst),
        .load(turn_load),
        .done(turn_done)
    );

    // Direction currently being driven (only meaningful in A2B/B2A)
    assign cur_dir = (state_q == A2B) ? DIR_A2B : DIR_B2A;

    // Next-state, turnaround load and switch-count update
    always_comb begin
        state_d      = state_q;
        prev_dir_d   = prev_dir_q;
        switch_cnt_d = switch_cnt_q;
        turn_load    = 1'b0;
        case (state_q)
            IDLE: begin
                // Nothing was driving, so no gap is needed
                if (en) begin
                    state_d = dir_state(dir_req);
                end
            end
            A2B, B2A: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (dir_req != cur_dir) begin
                    state_d    = TURN;
                    turn_load  = 1'b1;
                    prev_dir_d = cur_dir;
                end
            end
            TURN: begin
                // Gap length is fixed by the timer; dir_req only matters at exit
                if (turn_done) begin
                    if (!en) begin
                        state_d = IDLE;
                    end else begin
                        state_d = dir_state(dir_req);
                        if ((dir_req != prev_dir_q) && (switch_cnt_q != {CNT_W{1'b1}})) begin
                            switch_cnt_d = switch_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_dir_q   <= DIR_B2A;
            switch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_dir_q   <= prev_dir_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign drive_b    = (state_q == A2B);
    assign drive_a    = (state_q == B2A);
    assign turning    = (state_q == TURN);
    assign switch_cnt = switch_cnt_q;

`ifdef BIDIR_XCVR_REG_EN
    logic [WIDTH-1:0] data_ab_q;
    logic [WIDTH-1:0] data_ab_d;
    logic [WIDTH-1:0] data_ba_q;
    logic [WIDTH-1:0] data_ba_d;

    // Capture both buses every edge
    always_comb begin
        data_ab_d = a;
        data_ba_d = b;
    end

    // Data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ab_q <= '0;
            data_ba_q <= '0;
        end else begin
            data_ab_q <= data_ab_d;
            data_ba_q <= data_ba_d;
        end
    end

    assign data_ab = data_ab_q;
    assign data_ba = data_ba_q;
`else
    assign data_ab = a;
    assign data_ba = b;
`endif

    assign b = drive_b ? data_ab : {WIDTH{1'bz}};
    assign a = drive_a ? data_ba : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bidir_xcvr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bidir_xcvr
// Description : Self-checking bench for bidir_xcvr with a behavioural model
//               of direction, turnaround time and switch count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bidir_xcvr;

    localparam int WIDTH = 8;
    localparam int TC    = 2;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_AB   = 1;
    localparam int M_BA   = 2;
    localparam int M_TURN = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             dir_req;
    logic             a_oe;
    logic             b_oe;
    logic [WIDTH-1:0] a_drv;
    logic [WIDTH-1:0] b_drv;
    wire  [WIDTH-1:0] a_bus;
    wire  [WIDTH-1:0] b_bus;
    logic             drive_a;
    logic             drive_b;
    logic             turning;
    logic [CNT_W-1:0] switch_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_mode;
    int m_left;
    int m_before;
    int m_sw;

    always #5 clk = ~clk;

    assign a_bus = a_oe ? a_drv : {WIDTH{1'bz}};
    assign b_bus = b_oe ? b_drv : {WIDTH{1'bz}};

    bidir_xcvr #(
        .WIDTH      (WIDTH),
        .TURN_CYCLES(TC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_bus),
        .b         (b_bus),
        .en        (en),
        .dir_req   (dir_req),
        .drive_b   (drive_b),
        .drive_a   (drive_a),
        .turning   (turning),
        .switch_cnt(switch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the current inputs
    task automatic model_edge();
        int nd;
        if (rst) begin
            m_mode = M_IDLE;
            m_left = 0;
            m_sw   = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (en) m_mode = dir_req ? M_AB : M_BA;
                M_AB, M_BA: begin
                    nd = (m_mode == M_AB) ? 1 : 0;
                    if (!en) begin
                        m_mode = M_IDLE;
                    end else if (int'(dir_req) != nd) begin
                        m_before = nd;
                        m_left   = TC;
                        m_mode   = M_TURN;
                    end
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (!en) begin
                            m_mode = M_IDLE;
                        end else begin
                            m_mode = dir_req ? M_AB : M_BA;
                            if (int'(dir_req) != m_before && m_sw < MAXC) m_sw = m_sw + 1;
                        end
                    end
                end
            endcase
        end
    endtask

    // Advance one clock, update the model, re-drive the buses and compare
    task automatic tick();
        logic [WIDTH-1:0] a_edge;
        logic [WIDTH-1:0] b_edge;
        @(posedge clk);
        a_edge = a_drv;
        b_edge = b_drv;
        model_edge();
        a_oe  = (m_mode != M_BA);
        b_oe  = (m_mode != M_AB);
        a_drv = WIDTH'($urandom);
        b_drv = WIDTH'($urandom);
        #1;
        check("drive_b",    drive_b,    m_mode == M_AB);
        check("drive_a",    drive_a,    m_mode == M_BA);
        check("turning",    turning,    m_mode == M_TURN);
        check("switch_cnt", switch_cnt, m_sw);
        check("exclusive",  drive_a & drive_b, 1'b0);
`ifdef BIDIR_XCVR_REG_EN
        if (m_mode == M_AB) check("b_data", b_bus, a_edge);
        if (m_mode == M_BA) check("a_data", a_bus, b_edge);
`else
        if (m_mode == M_AB) check("b_data", b_bus, a_drv);
        if (m_mode == M_BA) check("a_data", a_bus, b_drv);
`endif
        if (m_mode == M_IDLE || m_mode == M_TURN) begin
            check("a_released", a_bus, a_drv);
            check("b_released", b_bus, b_drv);
        end
    endtask

    initial begin
        m_mode   = M_IDLE;
        m_left   = 0;
        m_before = 0;
        m_sw     = 0;
        rst      = 1'b1;
        en       = 1'b0;
        dir_req  = 1'b0;
        a_oe     = 1'b1;
        b_oe     = 1'b1;
        a_drv    = 8'h5A;
        b_drv    = 8'hC3;

        // Reset with both buses externally driven
        repeat (2) tick();
        check("rst_sw", switch_cnt, 0);

        // Enable toward b
        rst     = 1'b0;
        en      = 1'b1;
        dir_req = 1'b1;
        tick();
        check("a2b_first_edge", drive_b, 1'b1);
        tick();

        // Flip to b->a: exactly TC turning cycles then drive_a
        dir_req = 1'b0;
        repeat (TC) begin
            tick();
            check("turn_len", turning, 1'b1);
        end
        tick();
        check("b2a_after_turn", drive_a, 1'b1);
        check("first_switch", switch_cnt, 1);

        // Request flips back mid-turn: gap unchanged, no count
        dir_req = 1'b1;
        tick();
        dir_req = 1'b0;
        repeat (TC) tick();
        check("return_same_side", drive_a, 1'b1);
        check("return_no_count", switch_cnt, 1);

        // Reset during the first turnaround cycle
        dir_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_turn", {drive_a, drive_b, turning}, 3'b000);
        rst = 1'b0;
        tick();
        en = 1'b0;
        tick();
        check("release_no_turn", {drive_a, drive_b, turning}, 3'b000);

        // Saturation of the switch counter
        en = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            dir_req = ~dir_req;
            repeat (TC + 1) tick();
        end
        check("saturated", switch_cnt, MAXC);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) dir_req = ~dir_req;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
